// File: rtl/rrotate_seq.sv
// rrotate_seq: sequential right-rotate unit, one bit position per clock.
// A start captures the operand and rotate amount. The work register then
// rotates right once per cycle until the counter runs out. The result is
// latched into OUT, and done pulses for one cycle.
module rrotate_seq #(
  parameter int WIDTH = 4,
  parameter int SHW   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   shr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] OUT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] work_reg, work_next;
  logic [WIDTH-1:0] out_reg, out_next;
  logic [SHW-1:0]   cnt_reg, cnt_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] work_rot;

  // Rotate the work register right by one position.
  // Bit i takes bit i+1, and the MSB takes the old LSB.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rot
      assign work_rot[gi] = work_reg[(gi + 1) % WIDTH];
    end
  endgenerate

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_next = state_reg;
    work_next  = work_reg;
    cnt_next   = cnt_reg;
    out_next   = out_reg;
    case (state_reg)
      IDLE, DONE: begin
        // DONE accepts a new start, so back-to-back operations have no bubble.
        if (start) begin
          work_next = A;
          cnt_next  = shr;
          if (shr == '0) begin
            out_next   = A;
            state_next = DONE;
          end else begin
            state_next = SHIFT;
          end
        end else begin
          state_next = IDLE;
        end
      end
      SHIFT: begin
        // start, A and shr are ignored while a rotation is in flight.
        work_next = work_rot;
        cnt_next  = cnt_reg - SHW'(1);
        if (cnt_reg == SHW'(1)) begin
          out_next   = work_rot;
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // busy and done are decoded from the next state.
    // This lets them come straight from flops instead of state decode.
    busy_next = (state_next == SHIFT);
    done_next = (state_next == DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      cnt_reg   <= '0;
      out_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      work_reg  <= work_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign OUT  = out_reg;

endmodule

// File: tb/tb_rrotate_seq.sv
// tb_rrotate_seq: scoreboard bench for rrotate_seq.
// Stimulus pushes the expected result and done cycle into a queue.
// A monitor pops and compares whenever done is seen.
module tb_rrotate_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] A;
  logic [1:0] shr;
  logic       busy;
  logic       done;
  logic [3:0] OUT;

  typedef struct {
    logic [3:0] out;
    int         cyc;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   busy_cnt = 0;
  logic [3:0] last_out = 4'h0;

  rrotate_seq #(.WIDTH(4), .SHW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .shr   (shr),
    .busy  (busy),
    .done  (done),
    .OUT   (OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Count busy cycles, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (busy) busy_cnt++;
  end

  function automatic logic [3:0] rotr(input logic [3:0] a, input int s);
    int v;
    v = int'(a);
    return 4'(((v >> s) | (v << (4 - s))) & 15);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: each done pulse pops one expectation and checks result and timing.
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done with OUT=%h expected no done", OUT);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_out"}, int'(OUT), int'(e.out));
        chk({e.name, "_latency"}, cyc, e.cyc);
        chk({e.name, "_busy_with_done"}, int'(busy), 0);
        $display("txn %s: OUT=%h expected=%h cycle=%0d", e.name, OUT, e.out, cyc);
      end
    end
  end

  // Call at a negedge. The start is sampled at the next rising edge.
  task automatic issue(input logic [3:0] a, input logic [1:0] s, input string name);
    exp_t e;
    start  = 1'b1;
    A      = a;
    shr    = s;
    e.out  = rotr(a, int'(s));
    e.cyc  = cyc + 1 + int'(s);
    e.name = name;
    sb.push_back(e);
    last_out = e.out;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
    chk({name, "_out_held"}, int'(OUT), int'(last_out));
  endtask

  initial begin
    int b0;
    rst_n = 1'b0;
    start = 1'b1;
    A     = 4'hF;
    shr   = 2'd0;

    // Reset held for two cycles with start asserted.
    repeat (2) begin
      @(negedge clk);
      chk("reset_out", int'(OUT), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_out", int'(OUT), 0);
    chk("post_reset_busy", int'(busy), 0);

    // A=1011, shr=1: one busy cycle, OUT=1101.
    b0 = busy_cnt;
    issue(4'b1011, 2'd1, "rot_1011_by1");
    chk("model_1011_by1", int'(rotr(4'b1011, 1)), int'(4'b1101));
    @(negedge clk);
    start = 1'b0;
    wait_empty("rot_1011_by1");
    chk("busy_cycles_shr1", busy_cnt - b0, 1);

    // A=1000, shr=0: done on the next cycle, busy never high.
    b0 = busy_cnt;
    issue(4'b1000, 2'd0, "rot_1000_by0");
    @(negedge clk);
    start = 1'b0;
    wait_empty("rot_1000_by0");
    chk("busy_cycles_shr0", busy_cnt - b0, 0);

    // A=1000, shr=3: a start pulse while busy must be ignored.
    b0 = busy_cnt;
    issue(4'b1000, 2'd3, "rot_1000_by3");
    @(negedge clk);
    start = 1'b0;
    A     = 4'hF;
    shr   = 2'd0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_empty("rot_1000_by3");
    chk("busy_cycles_shr3", busy_cnt - b0, 3);

    // Back-to-back: the second start lands in the DONE cycle of the first.
    issue(4'b0110, 2'd2, "b2b_first");
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_done_before_restart", int'(done), 1);
    issue(4'b0001, 2'd1, "b2b_second");
    @(negedge clk);
    start = 1'b0;
    wait_empty("b2b");

    // Reset during the second SHIFT cycle abandons the operation.
    issue(4'b0011, 2'd3, "abort");
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    last_out = 4'h0;
    chk("abort_out", int'(OUT), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    repeat (5) @(negedge clk);
    chk("abort_out_after", int'(OUT), 0);

    // Exhaustive sweep of every operand and rotate amount.
    for (int a = 0; a < 16; a++) begin
      for (int s = 0; s < 4; s++) begin
        issue(4'(a), 2'(s), $sformatf("sweep_a%0d_s%0d", a, s));
        @(negedge clk);
        start = 1'b0;
        wait_empty("sweep");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
